// File: rtl/phase_sequence_monitor_if.sv
// Phase-monitor bundle: sample strobe, phase inputs, clear, and the
// registered lock/error/statistics outputs of phase_sequence_monitor.
interface phase_sequence_monitor_if #(
    parameter int CNT_W = 16
);
    logic             en;
    logic [2:0]       in_code;
    logic [5:0]       in_onehot;
    logic             clr;
    logic             locked;
    logic             err_pulse;
    logic             err_sticky;
    logic [7:0]       err_cnt;
    logic [CNT_W-1:0] cycle_cnt;

    // Upstream side: drives samples and clear, observes status.
    modport master (
        output en, in_code, in_onehot, clr,
        input  locked, err_pulse, err_sticky, err_cnt, cycle_cnt
    );

    // Monitor side.
    modport slave (
        input  en, in_code, in_onehot, clr,
        output locked, err_pulse, err_sticky, err_cnt, cycle_cnt
    );
endinterface

// File: rtl/phase_sequence_monitor.sv
// Watches a 6-state phase sequencer (code 000->001->011->111->110->100->000
// plus a one-hot copy lagging by one clock), locks after LOCK_COUNT
// consecutive legal transitions, and keeps error and cycle statistics.
module phase_sequence_monitor #(
    parameter int LOCK_COUNT = 6,
    parameter int CNT_W      = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    phase_sequence_monitor_if.slave  mon
);
    typedef enum logic [1:0] {
        S_IDLE,
        S_ACQUIRE,
        S_LOCKED
    } state_t;

    localparam logic [3:0] LC = 4'(LOCK_COUNT);

    state_t           r_state;
    logic [2:0]       r_prev_code;
    logic             r_prev_valid;
    logic [3:0]       r_streak;
    logic             r_locked;
    logic             r_err_pulse;
    logic             r_err_sticky;
    logic [7:0]       r_err_cnt;
    logic [CNT_W-1:0] r_cycle_cnt;

    logic [5:0]       w_exp_onehot;
    logic [2:0]       w_succ;
    logic             w_code_illegal;
    logic             w_check;
    logic             w_bad_step;
    logic             w_err;
    logic             w_legal;
    logic             w_wrap;
    logic [3:0]       w_streak_inc;

    // Expected one-hot and legal successor of the previous code; an illegal
    // previous code has no successor, so any change away from it is an error.
    always_comb begin
        w_exp_onehot = '0;
        w_succ       = r_prev_code;
        case (r_prev_code)
            3'b000: begin w_exp_onehot = 6'b100000; w_succ = 3'b001; end
            3'b001: begin w_exp_onehot = 6'b010000; w_succ = 3'b011; end
            3'b011: begin w_exp_onehot = 6'b001000; w_succ = 3'b111; end
            3'b111: begin w_exp_onehot = 6'b000100; w_succ = 3'b110; end
            3'b110: begin w_exp_onehot = 6'b000010; w_succ = 3'b100; end
            3'b100: begin w_exp_onehot = 6'b000001; w_succ = 3'b000; end
            default: ;
        endcase
    end

    assign w_code_illegal = (mon.in_code == 3'b010) || (mon.in_code == 3'b101);
    assign w_check        = mon.en && r_prev_valid && (r_state != S_IDLE);
    assign w_bad_step     = (mon.in_code != r_prev_code) && (mon.in_code != w_succ);
    assign w_err          = w_check && (w_code_illegal || w_bad_step ||
                                        (mon.in_onehot != w_exp_onehot));
    assign w_legal        = w_check && !w_err && (mon.in_code != r_prev_code);
    assign w_wrap         = w_legal && (r_state == S_LOCKED) &&
                            (r_prev_code == 3'b100) && (mon.in_code == 3'b000);
    assign w_streak_inc   = r_streak + 4'd1;

    // Lock FSM with sample history, streak and the registered lock/pulse outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_prev_code  <= '0;
            r_prev_valid <= 1'b0;
            r_streak     <= '0;
            r_locked     <= 1'b0;
            r_err_pulse  <= 1'b0;
        end else begin
            r_err_pulse <= w_err;
            if (mon.en) begin
                r_prev_code  <= mon.in_code;
                r_prev_valid <= 1'b1;
                case (r_state)
                    S_IDLE: begin
                        r_state  <= S_ACQUIRE;
                        r_streak <= '0;
                        r_locked <= 1'b0;
                    end
                    S_ACQUIRE: begin
                        if (w_err) begin
                            r_streak <= '0;
                        end else if (w_legal) begin
                            r_streak <= w_streak_inc;
                            if (w_streak_inc == LC) begin
                                r_state  <= S_LOCKED;
                                r_locked <= 1'b1;
                            end
                        end
                    end
                    S_LOCKED: begin
                        if (w_err) begin
                            r_state  <= S_ACQUIRE;
                            r_streak <= '0;
                            r_locked <= 1'b0;
                        end
                    end
                    default: begin
                        r_state  <= S_IDLE;
                        r_streak <= '0;
                        r_locked <= 1'b0;
                    end
                endcase
            end
        end
    end

    // Error and cycle statistics; clear takes priority over a same-edge increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err_sticky <= 1'b0;
            r_err_cnt    <= '0;
            r_cycle_cnt  <= '0;
        end else if (mon.clr) begin
            r_err_sticky <= 1'b0;
            r_err_cnt    <= '0;
            r_cycle_cnt  <= '0;
        end else begin
            if (w_err) begin
                r_err_sticky <= 1'b1;
                if (r_err_cnt != '1) begin
                    r_err_cnt <= r_err_cnt + 8'd1;
                end
            end
            if (w_wrap && (r_cycle_cnt != '1)) begin
                r_cycle_cnt <= r_cycle_cnt + 1'b1;
            end
        end
    end

    assign mon.locked     = r_locked;
    assign mon.err_pulse  = r_err_pulse;
    assign mon.err_sticky = r_err_sticky;
    assign mon.err_cnt    = r_err_cnt;
    assign mon.cycle_cnt  = r_cycle_cnt;
endmodule
